hazard_fwd_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage clkHI pipeline: tracks the destination register of every in-flight instruction in a shadow pipeline (EX, MEM, WB), drives the 3-bit selects of the two ALU-input forwarding mux8to1s, inserts one-cycle load-use stalls, and flushes younger stages on a taken branch resolved in MEM. Sits beside the IF/ID and ID/EX buffers. Replaces the fixed two-source forwarding decode with configurable address width, an optional WB write-through path, and stall/flush generation.

---
 rtl/hazard_fwd_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding control for the 5-stage clkHI pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_unit #(
  parameter int AW        = 5,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clkHI,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [AW-1:0]    id_dst,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic             pcsrc,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [2:0]       fwd_sel_a,
  output logic [2:0]       fwd_sel_b,
  input  logic [31:0]      wb_wd_in,
  output logic [31:0]      wb_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow copies of the destination info for the instructions in EX, MEM and WB.
  logic          e_v_q, e_wr_q, e_ld_q;
  logic [AW-1:0] e_dst_q;
  logic          m_v_q, m_wr_q;
  logic [AW-1:0] m_dst_q;
  logic          w_v_q, w_wr_q;
  logic [AW-1:0] w_dst_q;

  logic [2:0]    sel_a_q, sel_b_q;
  logic [2:0]    sel_a_d, sel_b_d;
  logic [31:0]   wb_hold_q;

  logic rs_e, rs_m, rs_w;
  logic rt_e, rt_m, rt_w;
  logic load_use;

  function automatic logic hit(input logic used, input logic v, input logic wr,
                               input logic [AW-1:0] dst, input logic [AW-1:0] src);
    return used & v & wr & (dst == src) & (src != '0);
  endfunction

  always_comb begin
    rs_e = hit(id_rs_used, e_v_q, e_wr_q, e_dst_q, id_rs);
    rs_m = hit(id_rs_used, m_v_q, m_wr_q, m_dst_q, id_rs);
    rs_w = hit(id_rs_used, w_v_q, w_wr_q, w_dst_q, id_rs);
    rt_e = hit(id_rt_used, e_v_q, e_wr_q, e_dst_q, id_rt);
    rt_m = hit(id_rt_used, m_v_q, m_wr_q, m_dst_q, id_rt);
    rt_w = hit(id_rt_used, w_v_q, w_wr_q, w_dst_q, id_rt);

    load_use = id_valid & e_ld_q & (rs_e | rt_e);

    // Reset beats a taken branch, and a taken branch beats a load-use stall.
    flush  = pcsrc & ~rst;
    stall  = load_use & ~pcsrc & ~rst;
    bubble = stall;

    sel_a_d = 3'd0;
    if (rs_e)                   sel_a_d = 3'd1;
    else if (rs_m)              sel_a_d = 3'd2;
    else if (rs_w && WB_BYPASS) sel_a_d = 3'd3;

    sel_b_d = 3'd0;
    if (rt_e)                   sel_b_d = 3'd1;
    else if (rt_m)              sel_b_d = 3'd2;
    else if (rt_w && WB_BYPASS) sel_b_d = 3'd3;
  end

  always_ff @(posedge clkHI) begin
    if (rst) begin
      e_v_q     <= 1'b0;
      e_wr_q    <= 1'b0;
      e_ld_q    <= 1'b0;
      e_dst_q   <= '0;
      m_v_q     <= 1'b0;
      m_wr_q    <= 1'b0;
      m_dst_q   <= '0;
      w_v_q     <= 1'b0;
      w_wr_q    <= 1'b0;
      w_dst_q   <= '0;
      sel_a_q   <= 3'd0;
      sel_b_q   <= 3'd0;
      wb_hold_q <= '0;
    end else begin
      wb_hold_q <= wb_wd_in;
      // The branch in MEM still retires, so WB always takes the MEM entry.
      w_v_q     <= m_v_q;
      w_wr_q    <= m_wr_q;
      w_dst_q   <= m_dst_q;
      if (flush) begin
        e_v_q   <= 1'b0;
        m_v_q   <= 1'b0;
        sel_a_q <= 3'd0;
        sel_b_q <= 3'd0;
      end else begin
        m_v_q   <= e_v_q;
        m_wr_q  <= e_wr_q;
        m_dst_q <= e_dst_q;
        e_v_q   <= id_valid & ~bubble;
        e_wr_q  <= id_regwr;
        e_ld_q  <= id_memrd;
        e_dst_q <= id_dst;
        sel_a_q <= bubble ? 3'd0 : sel_a_d;
        sel_b_q <= bubble ? 3'd0 : sel_b_d;
      end
    end
  end

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;
  assign wb_hold   = wb_hold_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clkHI) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: hand-derived pipeline scenarios, then random traffic
// checked against an in-flight-instruction model. Two DUTs: WB bypass on and off.
module tb_hazard_fwd_unit;
  localparam int AW  = 5;
  localparam int CW1 = 16;
  localparam int CW0 = 4;

`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clkHI = 1'b0;
  always #5 clkHI = ~clkHI;

  logic          rst, id_valid, id_rs_used, id_rt_used, id_regwr, id_memrd, pcsrc;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic [31:0]   wb_wd_in;

  logic           stall1, bubble1, flush1, stall0, bubble0, flush0;
  logic [2:0]     sel_a1, sel_b1, sel_a0, sel_b0;
  logic [31:0]    hold1, hold0;
  logic [CW1-1:0] scnt1, fcnt1;
  logic [CW0-1:0] scnt0, fcnt0;

  hazard_fwd_unit #(.AW(AW), .WB_BYPASS(1'b1), .CNT_W(CW1)) dut (
    .clkHI(clkHI), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .pcsrc(pcsrc),
    .stall(stall1), .bubble(bubble1), .flush(flush1),
    .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1), .wb_wd_in(wb_wd_in), .wb_hold(hold1),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  hazard_fwd_unit #(.AW(AW), .WB_BYPASS(1'b0), .CNT_W(CW0)) dut_nobyp (
    .clkHI(clkHI), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .pcsrc(pcsrc),
    .stall(stall0), .bubble(bubble0), .flush(flush0),
    .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0), .wb_wd_in(wb_wd_in), .wb_hold(hold0),
    .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cexp(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!CNT_ON) return 0;
    return (n > mx) ? mx : n;
  endfunction

  // ---------------- reference model ----------------
  // pipe[0] = instruction in EX, [1] = MEM, [2] = WB.
  typedef struct packed {
    logic          v;
    logic          wr;
    logic          ld;
    logic [AW-1:0] dst;
  } slot_t;

  slot_t       pipe[$];
  logic [2:0]  m_a1, m_b1, m_a0, m_b0;
  logic [2:0]  n_a1, n_b1, n_a0, n_b0;
  logic [31:0] m_hold;
  int          m_sc, m_fc;
  logic        e_stall, e_flush;

  // Index of the youngest in-flight producer of src, or -1.
  function automatic int producer(input logic used, input logic [AW-1:0] src);
    for (int i = 0; i < 3; i++)
      if (used && src != 0 && pipe[i].v && pipe[i].wr && pipe[i].dst == src) return i;
    return -1;
  endfunction

  // Producer in EX now sits in MEM when the reader reaches EX -> 1, MEM -> 2, WB -> 3.
  function automatic logic [2:0] sel_of(input int idx, input bit byp);
    if (idx < 0) return 3'd0;
    if (idx == 2) return byp ? 3'd3 : 3'd0;
    return 3'(idx + 1);
  endfunction

  task automatic model_eval();
    int pa, pb;
    pa = producer(id_rs_used, id_rs);
    pb = producer(id_rt_used, id_rt);
    e_flush = pcsrc && !rst;
    e_stall = id_valid && !rst && !pcsrc && pipe[0].ld && (pa == 0 || pb == 0);
    n_a1 = sel_of(pa, 1'b1);
    n_b1 = sel_of(pb, 1'b1);
    n_a0 = sel_of(pa, 1'b0);
    n_b0 = sel_of(pb, 1'b0);
  endtask

  task automatic model_commit();
    slot_t nop, cur;
    nop = '0;
    if (rst) begin
      pipe = '{nop, nop, nop};
      m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
      m_hold = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_hold = wb_wd_in;
      m_sc += int'(e_stall);
      m_fc += int'(e_flush);
      if (e_flush) begin
        cur  = pipe[1];
        pipe = '{nop, nop, cur};
        m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
      end else begin
        cur = nop;
        if (id_valid && !e_stall) cur = '{1'b1, id_regwr, id_memrd, id_dst};
        pipe.push_front(cur);
        void'(pipe.pop_back());
        m_a1 = e_stall ? 3'd0 : n_a1;
        m_b1 = e_stall ? 3'd0 : n_b1;
        m_a0 = e_stall ? 3'd0 : n_a0;
        m_b0 = e_stall ? 3'd0 : n_b0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, v, ru, tu, wr, ld, br;
    logic [AW-1:0] rs, rt, dst;
    logic [31:0]   wd;
    logic          es, ef;
    logic [2:0]    ea, eb;
    logic          chk_hold;
    logic [31:0]   eh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int r, input int v, input int rs, input int ru,
                              input int rt, input int tu, input int dst, input int wr,
                              input int ld, input int br, input int es, input int ef,
                              input int ea, input int eb);
    vec_t x;
    x.rst = r[0]; x.v = v[0]; x.rs = AW'(rs); x.ru = ru[0]; x.rt = AW'(rt); x.tu = tu[0];
    x.dst = AW'(dst); x.wr = wr[0]; x.ld = ld[0]; x.br = br[0]; x.wd = 32'h0;
    x.es = es[0]; x.ef = ef[0]; x.ea = 3'(ea); x.eb = 3'(eb);
    x.chk_hold = 1'b0; x.eh = 32'h0;
    return x;
  endfunction

  task automatic drive(input vec_t r);
    rst = r.rst; id_valid = r.v; id_rs = r.rs; id_rs_used = r.ru; id_rt = r.rt;
    id_rt_used = r.tu; id_dst = r.dst; id_regwr = r.wr; id_memrd = r.ld;
    pcsrc = r.br; wb_wd_in = r.wd;
  endtask

  task automatic build_table();
    //          rst v  rs ru rt tu dst wr ld br   es ef ea eb
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0)); // 0 reset state
    tbl.push_back(mk(0, 1, 1, 1, 2, 1, 3, 1, 0, 0,   0, 0, 0, 0)); // 1 ADD r3
    tbl.push_back(mk(0, 1, 3, 1, 4, 1, 5, 1, 0, 0,   0, 0, 0, 0)); // 2 ADD r5,r3,r4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0)); // 3 EX->MEM forward
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 2, 1, 1, 0,   0, 0, 0, 0)); // 4 LW r2
    tbl.push_back(mk(0, 1, 1, 1, 2, 1, 6, 1, 0, 0,   1, 0, 0, 0)); // 5 SUB r6,r1,r2 stalls
    tbl.push_back(mk(0, 1, 1, 1, 2, 1, 6, 1, 0, 0,   0, 0, 0, 0)); // 6 SUB held, bubble sel
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2)); // 7 load from MEM/WB
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0)); // 8 writer r7
    tbl.push_back(mk(0, 1, 9, 1,10, 1, 8, 1, 0, 0,   0, 0, 0, 0)); // 9 independent
    tbl.push_back(mk(0, 1,12, 1,13, 1,11, 1, 0, 0,   0, 0, 0, 0)); // 10 independent
    tbl.push_back(mk(0, 1,14, 1, 7, 1,15, 1, 0, 0,   0, 0, 0, 0)); // 11 reader r7
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3)); // 12 WB+1 path
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0)); // 13 LW r0
    tbl.push_back(mk(0, 1, 0, 1, 0, 1,16, 1, 0, 0,   0, 0, 0, 0)); // 14 reader r0: no stall
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,21, 1, 0, 0,   0, 0, 0, 0)); // 15 writer r21, sel 0
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4, 1, 1, 0,   0, 0, 0, 0)); // 16 LW r4
    tbl.push_back(mk(0, 1, 4, 1, 0, 0,17, 1, 0, 1,   0, 1, 0, 0)); // 17 load-use + branch
    tbl.push_back(mk(0, 1, 4, 1,21, 1,18, 1, 0, 0,   0, 0, 0, 0)); // 18 after flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3)); // 19 r21 survived in WB
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 9, 1, 1, 0,   0, 0, 0, 0)); // 20 LW r9
    tbl.push_back(mk(1, 1, 0, 0, 9, 1,19, 1, 0, 0,   0, 0, 0, 0)); // 21 rst during stall
    tbl.push_back(mk(0, 1, 1, 1, 2, 1,20, 1, 0, 0,   0, 0, 0, 0)); // 22 all cleared
    tbl.push_back(mk(0, 1,20, 1,20, 1,22, 1, 0, 0,   0, 0, 0, 0)); // 23 reader r20 both
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1)); // 24 forwards normally
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0)); // 25 branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0)); // 26 back-to-back branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0)); // 27 counts settle
    tbl[11].wd       = 32'hDEAD_0007;
    tbl[12].chk_hold = 1'b1;
    tbl[12].eh       = 32'hDEAD_0007;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   sc, fc;
    vec_t r;
    logic hold_id;
    slot_t nop;
    nop  = '0;
    pipe = '{nop, nop, nop};
    build_table();

    r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clkHI);
      drive(r);
      #1;
      model_eval();
      model_commit();
    end

    sc = 0;
    fc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      @(negedge clkHI);
      drive(r);
      #1;
      model_eval();
      if (!r.rst) begin
        chk($sformatf("t%0d stall", i),   32'(stall1),  32'(r.es));
        chk($sformatf("t%0d bubble", i),  32'(bubble1), 32'(r.es));
        chk($sformatf("t%0d flush", i),   32'(flush1),  32'(r.ef));
        chk($sformatf("t%0d stall_nb", i), 32'(stall0), 32'(r.es));
        chk($sformatf("t%0d flush_nb", i), 32'(flush0), 32'(r.ef));
      end
      chk($sformatf("t%0d sel_a", i),    32'(sel_a1), 32'(r.ea));
      chk($sformatf("t%0d sel_b", i),    32'(sel_b1), 32'(r.eb));
      chk($sformatf("t%0d sel_a_nb", i), 32'(sel_a0), 32'((r.ea == 3'd3) ? 3'd0 : r.ea));
      chk($sformatf("t%0d sel_b_nb", i), 32'(sel_b0), 32'((r.eb == 3'd3) ? 3'd0 : r.eb));
      chk($sformatf("t%0d stall_cnt", i), 32'(scnt1), 32'(cexp(sc, CW1)));
      chk($sformatf("t%0d flush_cnt", i), 32'(fcnt1), 32'(cexp(fc, CW1)));
      if (r.chk_hold) begin
        chk($sformatf("t%0d wb_hold", i),    hold1, r.eh);
        chk($sformatf("t%0d wb_hold_nb", i), hold0, r.eh);
      end
      model_commit();
      if (r.rst) begin
        sc = 0;
        fc = 0;
      end else begin
        sc += int'(r.es);
        fc += int'(r.ef);
      end
    end

    // Random traffic; a stalled ID instruction is held like the real IF/ID would.
    hold_id = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clkHI);
      if (!hold_id) begin
        id_valid   = ($urandom_range(0, 9) < 8);
        id_rs      = AW'($urandom_range(0, 7));
        id_rt      = AW'($urandom_range(0, 7));
        id_rs_used = 1'($urandom_range(0, 1));
        id_rt_used = 1'($urandom_range(0, 1));
        id_dst     = AW'($urandom_range(0, 7));
        id_regwr   = ($urandom_range(0, 3) != 0);
        id_memrd   = ($urandom_range(0, 9) < 3);
      end
      pcsrc    = ($urandom_range(0, 11) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      wb_wd_in = $urandom;
      #1;
      model_eval();
      chk($sformatf("r%0d stall", cyc),     32'(stall1),  32'(e_stall));
      chk($sformatf("r%0d bubble", cyc),    32'(bubble1), 32'(e_stall));
      chk($sformatf("r%0d flush", cyc),     32'(flush1),  32'(e_flush));
      chk($sformatf("r%0d bubble_nb", cyc), 32'(bubble0), 32'(e_stall));
      chk($sformatf("r%0d flush_nb", cyc),  32'(flush0),  32'(e_flush));
      chk($sformatf("r%0d sel_a", cyc),     32'(sel_a1),  32'(m_a1));
      chk($sformatf("r%0d sel_b", cyc),     32'(sel_b1),  32'(m_b1));
      chk($sformatf("r%0d sel_a_nb", cyc),  32'(sel_a0),  32'(m_a0));
      chk($sformatf("r%0d sel_b_nb", cyc),  32'(sel_b0),  32'(m_b0));
      chk($sformatf("r%0d wb_hold", cyc),   hold1,        m_hold);
      chk($sformatf("r%0d stall_cnt", cyc), 32'(scnt1),   32'(cexp(m_sc, CW1)));
      chk($sformatf("r%0d flush_cnt", cyc), 32'(fcnt1),   32'(cexp(m_fc, CW1)));
      chk($sformatf("r%0d stall_cnt_nb", cyc), 32'(scnt0), 32'(cexp(m_sc, CW0)));
      chk($sformatf("r%0d flush_cnt_nb", cyc), 32'(fcnt0), 32'(cexp(m_fc, CW0)));
      hold_id = e_stall;
      model_commit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
